wavetable_synth_i2s: RTL

WAVETABLE_SYNTH_I2S -- requirements
Module: wavetable_synth_i2s

---
 rtl/synth_pkg.sv | 21 ++
 rtl/i2s_tx_shift.sv | 45 ++++
 rtl/wavetable_synth_i2s.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the wavetable synthesizer.
// Holds the mixer FSM state type and the bit offsets of the fields packed
// into a voice configuration word ({key code, divider}).
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MIX    = 2'd1,
    COMMIT = 2'd2
  } mix_state_t;

  // Configuration word layout: divider in the low DIV_W bits, 8-bit key above it.
  localparam int CFG_KEY_W   = 8;
  localparam int CFG_DIV_LSB = 0;

  // The key field sits directly above the divider, so its offset depends on DIV_W.
  function automatic int cfg_key_lsb(input int div_w);
    return div_w;
  endfunction

endpackage

// File: rtl/i2s_tx_shift.sv
// I2S transmit shift register.
// Ports:
//   CLK, RESET  system clock, asynchronous active-high reset
//   load        capture din; the MSB goes out on the next sclk_fall
//   din         sample word to transmit
//   sclk_fall   single-cycle strobe marking a falling SCLK edge
//   dout        serial data, MSB first, 0 once all bits have been sent
module i2s_tx_shift #(
  parameter int SAMPLE_W = 24
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                load,
  input  logic [SAMPLE_W-1:0] din,
  input  logic                sclk_fall,
  output logic                dout
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  logic [SAMPLE_W-1:0] shift_reg;
  logic [CNT_W-1:0]    bits_left;

  // Load wins over a coincident sclk_fall: LRCLK changes on the same SCLK
  // edge, so the MSB must wait for the following falling edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shift_reg <= '0;
      bits_left <= '0;
      dout      <= 1'b0;
    end else if (load) begin
      shift_reg <= din;
      bits_left <= CNT_W'(SAMPLE_W);
    end else if (sclk_fall) begin
      if (bits_left != '0) begin
        dout      <= shift_reg[SAMPLE_W-1];
        shift_reg <= {shift_reg[SAMPLE_W-2:0], 1'b0};
        bits_left <= bits_left - CNT_W'(1);
      end else begin
        dout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wavetable_synth_i2s.sv
// Multi-voice wavetable synthesizer with I2S output.
// Each voice steps through a shared wavetable once every (divider+1) frames
// while its key code is held; the active voices are summed once per frame,
// saturated, and sent on both I2S channels.
// Ports:
//   CLK, RESET              system clock, asynchronous active-high reset
//   key_codes               KEY_SLOTS held key codes, 0x00 = empty slot
//   SCLK, LRCLK             I2S bit clock / word select (asynchronous inputs)
//   Dout                    I2S serial data
//   tbl_addr/write/wdata    wavetable write port, tbl_rdata combinational read
//   cfg_addr/write/wdata    voice config write port {key, divider}, cfg_rdata read
//   busy                    mixer is working on a frame
module wavetable_synth_i2s
  import synth_pkg::*;
#(
  parameter int NUM_VOICES  = 12,
  parameter int SAMPLE_W    = 24,
  parameter int TABLE_DEPTH = 8,
  parameter int DIV_W       = 16,
  parameter int KEY_SLOTS   = 8
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [8*KEY_SLOTS-1:0]         key_codes,
  input  logic                           SCLK,
  input  logic                           LRCLK,
  output logic                           Dout,
  input  logic [$clog2(TABLE_DEPTH)-1:0] tbl_addr,
  input  logic                           tbl_write,
  input  logic [SAMPLE_W-1:0]            tbl_wdata,
  output logic [SAMPLE_W-1:0]            tbl_rdata,
  input  logic [$clog2(NUM_VOICES)-1:0]  cfg_addr,
  input  logic                           cfg_write,
  input  logic [8+DIV_W-1:0]             cfg_wdata,
  output logic [8+DIV_W-1:0]             cfg_rdata,
  output logic                           busy
);

  localparam int PH_W    = $clog2(TABLE_DEPTH);
  localparam int VI_W    = $clog2(NUM_VOICES);
  localparam int ACC_W   = SAMPLE_W + VI_W;
  localparam int KEY_LSB = cfg_key_lsb(DIV_W);

  // Synchronizers: [0],[1] resynchronize, [2] is the history bit for edge detection.
  logic [2:0] sclk_sync;
  logic [2:0] lr_sync;
  logic       sclk_fall, lr_rise, lr_edge;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sclk_sync <= '0;
      lr_sync   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], SCLK};
      lr_sync   <= {lr_sync[1:0], LRCLK};
    end
  end

  assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
  assign lr_rise   = ~lr_sync[2] & lr_sync[1];
  assign lr_edge   = lr_sync[2] ^ lr_sync[1];

  // Wavetable and voice configuration memories (resettable, combinational read).
  logic [SAMPLE_W-1:0]  tbl_mem [TABLE_DEPTH];
  logic [CFG_KEY_W-1:0] key_mem [NUM_VOICES];
  logic [DIV_W-1:0]     div_mem [NUM_VOICES];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < TABLE_DEPTH; i++) tbl_mem[i] <= '0;
    end else if (tbl_write) begin
      tbl_mem[tbl_addr] <= tbl_wdata;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_mem[v] <= '0;
        div_mem[v] <= '0;
      end
    end else if (cfg_write && int'(cfg_addr) < NUM_VOICES) begin
      key_mem[cfg_addr] <= cfg_wdata[KEY_LSB +: CFG_KEY_W];
      div_mem[cfg_addr] <= cfg_wdata[CFG_DIV_LSB +: DIV_W];
    end
  end

  assign tbl_rdata = tbl_mem[tbl_addr];

  always_comb begin
    cfg_rdata = '0;
    if (int'(cfg_addr) < NUM_VOICES) cfg_rdata = {key_mem[cfg_addr], div_mem[cfg_addr]};
  end

  // Key matching: a voice plays while any slot holds its (nonzero) key code.
  logic [NUM_VOICES-1:0] active;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_match
    logic [KEY_SLOTS-1:0] slot_hit;
    for (genvar gs = 0; gs < KEY_SLOTS; gs++) begin : g_slot
      assign slot_hit[gs] = (key_codes[8*gs +: 8] == key_mem[gi]);
    end
    assign active[gi] = (|slot_hit) && (key_mem[gi] != 8'h00);
  end

  // Per-voice frame dividers and phases. The mixer works from a snapshot
  // taken at lr_rise, so it sees the phases as they were before this update.
  mix_state_t            state;
  logic [DIV_W-1:0]      div_cnt    [NUM_VOICES];
  logic [PH_W-1:0]       phase      [NUM_VOICES];
  logic [PH_W-1:0]       snap_phase [NUM_VOICES];
  logic [NUM_VOICES-1:0] snap_active;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        div_cnt[v]    <= '0;
        phase[v]      <= '0;
        snap_phase[v] <= '0;
      end
      snap_active <= '0;
    end else if (lr_rise) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        // A rise while busy must not disturb the frame being mixed.
        if (state == IDLE) begin
          snap_phase[v]  <= phase[v];
          snap_active[v] <= active[v];
        end
        if (!active[v]) begin
          div_cnt[v] <= '0;
          phase[v]   <= '0;
        end else if (div_cnt[v] >= div_mem[v]) begin
          div_cnt[v] <= '0;
          phase[v]   <= phase[v] + PH_W'(1);
        end else begin
          div_cnt[v] <= div_cnt[v] + DIV_W'(1);
        end
      end
    end
  end

  // Mixer: one voice per cycle, then saturate and commit.
  logic [VI_W-1:0]         voice_idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic [SAMPLE_W-1:0]     mix_word;
  logic [SAMPLE_W-1:0]     sat_sample;
  logic [SAMPLE_W-1:0]     out_sample;
  logic [ACC_W-SAMPLE_W:0] acc_top;
  logic                    busy_reg;

  // The table is read live, so a write lands in the mix from the next cycle.
  assign mix_word = tbl_mem[snap_phase[voice_idx]];

  always_comb begin
    term = '0;
    if (snap_active[voice_idx]) term = {{(ACC_W-SAMPLE_W){mix_word[SAMPLE_W-1]}}, mix_word};
  end

  // In range when every bit from the sample's sign bit upward agrees.
  assign acc_top = acc[ACC_W-1:SAMPLE_W-1];

  always_comb begin
    if (acc_top == '0 || acc_top == '1) sat_sample = acc[SAMPLE_W-1:0];
    else if (acc[ACC_W-1])              sat_sample = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else                                sat_sample = {1'b0, {(SAMPLE_W-1){1'b1}}};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      voice_idx  <= '0;
      acc        <= '0;
      out_sample <= '0;
      busy_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lr_rise) begin
            state     <= MIX;
            voice_idx <= '0;
            acc       <= '0;
            busy_reg  <= 1'b1;
          end
        end
        MIX: begin
          acc <= acc + term;
          if (voice_idx == VI_W'(NUM_VOICES - 1)) state <= COMMIT;
          else voice_idx <= voice_idx + VI_W'(1);
        end
        COMMIT: begin
          out_sample <= sat_sample;
          state      <= IDLE;
          busy_reg   <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;

  // Reloaded on both LRCLK edges so left and right carry the same sample.
  i2s_tx_shift #(.SAMPLE_W(SAMPLE_W)) u_tx (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (lr_edge),
    .din       (out_sample),
    .sclk_fall (sclk_fall),
    .dout      (Dout)
  );

endmodule
